// File: rtl/cache_evict_buffer.sv
// cache_evict_buffer
//   Writeback buffer behind a direct-mapped write-back cache. Takes whole
//   dirty 64-byte victim lines so the cache can start its refill at once,
//   then drains the oldest line to memory as 16 sequential 4-byte writes.
//   The line retires when all 16 write acks have come back. A line-address
//   lookup lets the cache stall a refill whose line is still in here.
//
//   Optional feature macro: CACHE_EVICT_BUFFER_FWD_EN
//     defined   : lookup_data_o returns word lookup_addr_i[5:2] of the
//                 youngest matching entry (0 on miss)
//     undefined : lookup_data_o is tied to 0
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   in_val_i/in_rdy_o      victim line handshake
//   in_addr_i, in_data_i   line address ([5:0] ignored), 16x32-bit words
//   memreq_*               write requests {type_,opaque,addr,len,data}
//   memresp_*              write acks (only type_ is examined)
//   lookup_addr_i          line address probe
//   lookup_hit_o/_data_o   probe result
//   empty_o                no stored lines
//   err_o                  sticky protocol error (stray ack / non-write resp)
module cache_evict_buffer #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_val_i,
  output logic         in_rdy_o,
  input  logic [31:0]  in_addr_i,
  input  logic [511:0] in_data_i,
  output logic         memreq_val_o,
  input  logic         memreq_rdy_i,
  output logic [76:0]  memreq_msg_o,
  input  logic         memresp_val_i,
  output logic         memresp_rdy_o,
  input  logic [46:0]  memresp_msg_i,
  input  logic [31:0]  lookup_addr_i,
  output logic         lookup_hit_o,
  output logic [31:0]  lookup_data_o,
  output logic         empty_o,
  output logic         err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [4:0]    MAXO  = 5'(MAX_OUTSTANDING);
  localparam logic [2:0]    WRITE = 3'd1;

  typedef enum logic [0:0] {IDLE, SEND} state_e;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  state_e               state_q;
  logic [DEPTH-1:0]     valid_q;
  logic [25:0]          line_q [DEPTH];
  logic [511:0]         data_q [DEPTH];
  logic [PW-1:0]        head_q, tail_q;
  logic [CW-1:0]        count_q, count_d;
  logic [4:0]           send_idx_q;   // next word to issue, 0..16
  logic [4:0]           ack_cnt_q;    // acks received for head line
  logic [4:0]           out_q;        // issued but not yet acked
  logic                 err_q;

  mem_resp_4B_t rsp;
  mem_req_4B_t  req;
  logic push, fire, ack, bad_resp, retire, sending;

  assign rsp     = mem_resp_4B_t'(memresp_msg_i);
  assign sending = (state_q == SEND);

  // in_rdy looks only at the registered count, so a full buffer stays
  // full in the cycle its head retires.
  assign in_rdy_o      = rst_ni && (count_q != FULL);
  assign memresp_rdy_o = rst_ni;
  assign empty_o       = (count_q == '0);
  assign err_o         = err_q;

  assign push         = in_val_i && in_rdy_o;
  assign memreq_val_o = sending && (send_idx_q < 5'd16) && (out_q < MAXO);
  assign fire         = memreq_val_o && memreq_rdy_i;

  // An ack only counts while draining with something outstanding;
  // anything else is consumed and flagged.
  assign ack      = memresp_val_i && sending && (out_q != '0);
  assign bad_resp = memresp_val_i && (!ack || (rsp.type_ != WRITE));
  assign retire   = ack && (ack_cnt_q == 5'd15);
  assign count_d  = count_q + CW'(push) - CW'(retire);

  always_comb begin
    req        = '0;
    req.type_  = WRITE;
    req.opaque = {3'b000, send_idx_q};
    req.addr   = {line_q[head_q], send_idx_q[3:0], 2'b00};
    req.len    = 2'd0;
    req.data   = data_q[head_q][{send_idx_q[3:0], 5'd0} +: 32];
  end
  assign memreq_msg_o = req;

  // Walk oldest to youngest so the youngest match is the one left standing.
  logic [PW-1:0] lk_idx;
  always_comb begin
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    lk_idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if (valid_q[lk_idx] && (line_q[lk_idx] == lookup_addr_i[31:6])) begin
        lookup_hit_o = 1'b1;
`ifdef CACHE_EVICT_BUFFER_FWD_EN
        lookup_data_o = data_q[lk_idx][{lookup_addr_i[5:2], 5'd0} +: 32];
`endif
      end
    end
  end

  // Line storage carries no reset; valid_q gates every use.
  always_ff @(posedge clk_i) begin
    if (push) begin
      line_q[tail_q] <= in_addr_i[31:6];
      data_q[tail_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      send_idx_q <= '0;
      ack_cnt_q  <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      // push and retire never target the same slot: retire needs count>=1
      // and push needs count<DEPTH, so tail != head whenever both happen.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      count_q <= count_d;
      if (bad_resp) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (count_q != '0) state_q <= SEND;
        end
        SEND: begin
          out_q <= out_q + 5'(fire) - 5'(ack);
          if (fire) send_idx_q <= send_idx_q + 5'd1;
          if (ack)  ack_cnt_q  <= ack_cnt_q + 5'd1;
          if (retire) begin
            send_idx_q <= '0;
            ack_cnt_q  <= '0;
            state_q    <= (count_d != '0) ? SEND : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{in_addr_i[5:0], lookup_addr_i[5:0], rsp.opaque,
                         rsp.test, rsp.len, rsp.data};

endmodule

// File: tb/tb_cache_evict_buffer.sv
// Self-checking bench for cache_evict_buffer. A queue-of-lines model tracks
// what is buffered, how far the head line has been sent/acked and the sticky
// error; every cycle the DUT outputs are compared against it. A scoreboarded
// memory responder returns one ack per issued write after a set latency.
module tb_cache_evict_buffer;
  localparam int DEPTH = 2;
  localparam int MAXO  = 4;
  localparam logic [46:0] RSP_WR = {3'd1, 44'd0};

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         in_val;
  logic         in_rdy;
  logic [31:0]  in_addr;
  logic [511:0] in_data;
  logic         memreq_val;
  logic         memreq_rdy;
  logic [76:0]  memreq_msg;
  logic         memresp_val;
  logic         memresp_rdy;
  logic [46:0]  memresp_msg;
  logic [31:0]  lookup_addr;
  logic         lookup_hit;
  logic [31:0]  lookup_data;
  logic         empty;
  logic         err;

  cache_evict_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_val_i(in_val), .in_rdy_o(in_rdy), .in_addr_i(in_addr), .in_data_i(in_data),
    .memreq_val_o(memreq_val), .memreq_rdy_i(memreq_rdy), .memreq_msg_o(memreq_msg),
    .memresp_val_i(memresp_val), .memresp_rdy_o(memresp_rdy), .memresp_msg_i(memresp_msg),
    .lookup_addr_i(lookup_addr), .lookup_hit_o(lookup_hit), .lookup_data_o(lookup_data),
    .empty_o(empty), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [25:0]  line;
    logic [511:0] data;
  } ent_t;

  // reference model
  ent_t q[$];
  int   m_sent, m_acked, m_out;
  bit   m_err, active, in_reset;
  int   rq[$];            // due cycle of each owed ack
  bit   auto_ack, man_ack;
  int   lat;
  int   cyc;
  int   dut_fires, dut_accept_cyc, last_retire_cyc;
  int   errors, checks;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mkdata(input logic [31:0] base);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = base + 32'(k);
    return d;
  endfunction

  function automatic logic [511:0] rnddata();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_lookup(input logic [31:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].line == a[31:6]) begin
        h = 1'b1;
`ifdef CACHE_EVICT_BUFFER_FWD_EN
        d = q[i].data[32*int'(a[5:2]) +: 32];
`endif
        break;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    rq.delete();
    m_sent = 0; m_acked = 0; m_out = 0; m_err = 0; active = 0;
  endtask

  // One clock cycle: drive responder, compare outputs, advance the model.
  task automatic tick();
    logic        e_val, e_hit, fire, push, retire;
    logic [31:0] e_data;
    logic [76:0] e_msg;
    int          size_before;
    @(negedge clk);
    memresp_val = 1'b0;
    if (man_ack) begin
      memresp_val = 1'b1;
      if (rq.size() > 0) rq.delete(0);
      man_ack = 0;
    end else if (auto_ack && rq.size() > 0 && rq[0] <= cyc) begin
      memresp_val = 1'b1;
      rq.delete(0);
    end
    #1;
    if (in_reset) begin
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_memreq_val", memreq_val, 0);
      chk("rst_memresp_rdy", memresp_rdy, 0);
      chk("rst_hit", lookup_hit, 0);
      chk("rst_data", lookup_data, 0);
      chk("rst_empty", empty, 1);
      chk("rst_err", err, 0);
    end else begin
      e_val = active && (m_sent < 16) && (m_out < MAXO);
      model_lookup(lookup_addr, e_hit, e_data);
      chk("in_rdy", in_rdy, q.size() != DEPTH);
      chk("memresp_rdy", memresp_rdy, 1);
      chk("memreq_val", memreq_val, e_val);
      chk("empty", empty, q.size() == 0);
      chk("err", err, m_err);
      chk("lookup_hit", lookup_hit, e_hit);
      chk("lookup_data", lookup_data, e_data);
      if (e_val) begin
        e_msg = {3'd1, 8'(m_sent), q[0].line, 4'(m_sent), 2'b00, 2'b00,
                 q[0].data[32*m_sent +: 32]};
        chk("memreq_msg", memreq_msg, e_msg);
      end
      if (memreq_val && memreq_rdy) dut_fires++;
      if (in_val && in_rdy) dut_accept_cyc = cyc;

      fire        = e_val && memreq_rdy;
      push        = in_val && (q.size() != DEPTH);
      size_before = q.size();
      retire      = 1'b0;
      if (memresp_val) begin
        if (!active || m_out == 0) m_err = 1;
        else begin
          m_acked++;
          m_out--;
          if (m_acked == 16) retire = 1'b1;
        end
      end
      if (fire) begin
        m_sent++;
        m_out++;
        rq.push_back(cyc + lat);
      end
      if (retire) begin
        void'(q.pop_front());
        m_sent = 0;
        m_acked = 0;
        last_retire_cyc = cyc;
      end
      if (push) q.push_back('{line: in_addr[31:6], data: in_data});
      if (!active) active = (size_before != 0);
      else if (retire) active = (q.size() != 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_line(input logic [31:0] a, input logic [511:0] d);
    in_val = 1'b1; in_addr = a; in_data = d;
    tick();
    in_val = 1'b0;
  endtask

  task automatic wait_empty(input int maxc, input string tag);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, empty, 1);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; lat = 2;
    dut_fires = 0; dut_accept_cyc = -1; last_retire_cyc = -1;
    auto_ack = 0; man_ack = 0;
    rst_ni = 1'b0; in_reset = 1;
    in_val = 0; in_addr = '0; in_data = '0;
    memreq_rdy = 0; memresp_val = 0; memresp_msg = RSP_WR; lookup_addr = '0;
    model_reset();
    repeat (3) tick();
    rst_ni = 1'b1; in_reset = 0;

    // single line, acks 2 cycles after each request
    memreq_rdy = 1; auto_ack = 1; lat = 2; dut_fires = 0;
    push_line(32'h0000_1040, mkdata(32'hA000_0000));
    wait_empty(200, "t1_drain");
    chk("t1_fires", dut_fires, 16);

    // acks withheld: outstanding cap, then one ack frees one slot
    auto_ack = 0; dut_fires = 0;
    push_line(32'h0000_6000, mkdata(32'h6000_0000));
    repeat (20) tick();
    chk("t2_fires_cap", dut_fires, 4);
    chk("t2_val_low", memreq_val, 0);
    man_ack = 1;
    repeat (10) tick();
    chk("t2_fires_one_more", dut_fires, 5);
    auto_ack = 1;
    wait_empty(200, "t2_drain");

    // fill with memory stalled, probe, then drain the first line
    memreq_rdy = 0;
    push_line(32'h0000_2000, mkdata(32'h2000_0000));
    push_line(32'h0000_3000, mkdata(32'h3000_0000));
    chk("t3_full_rdy", in_rdy, 0);
    lookup_addr = 32'h0000_3004; #1;
    chk("t3_hit_3004", lookup_hit, 1);
    lookup_addr = 32'h0000_4000; #1;
    chk("t3_miss_4000", lookup_hit, 0);
    lookup_addr = 32'h0000_3004;
    memreq_rdy = 1;
    for (int n = 0; n < 200 && q.size() != 1; n++) tick();
    chk("t3_rdy_after_retire", in_rdy, 1);
    chk("t3_hit_still", lookup_hit, 1);
    wait_empty(200, "t3_drain");

    // push offered continuously while full: accepted the cycle after retire
    push_line(32'h0000_7000, mkdata(32'h7000_0000));
    push_line(32'h0000_8000, mkdata(32'h8000_0000));
    in_val = 1; in_addr = 32'h0000_9000; in_data = mkdata(32'h9000_0000);
    dut_accept_cyc = -1;
    for (int n = 0; n < 200 && dut_accept_cyc < 0; n++) tick();
    in_val = 0;
    chk("t4_accept_after_retire", dut_accept_cyc, last_retire_cyc + 1);
    wait_empty(300, "t4_drain");

    // randomized traffic with recurring line addresses
    for (int n = 0; n < 1200; n++) begin
      in_val      = ($urandom_range(0, 2) == 0);
      in_addr     = {20'h00010, 4'($urandom_range(0, 3)), 8'($urandom)};
      in_data     = rnddata();
      memreq_rdy  = ($urandom_range(0, 9) < 7);
      lat         = $urandom_range(1, 4);
      lookup_addr = {20'h00010, 4'($urandom_range(0, 4)), 8'($urandom)};
      tick();
    end
    in_val = 0; memreq_rdy = 1; lat = 2;
    wait_empty(400, "rnd_drain");

    // stray ack with nothing buffered sets sticky err
    man_ack = 1;
    tick();
    chk("t5_err_set", err, 1);
    repeat (5) tick();
    chk("t5_err_sticky", err, 1);

    // reset in the middle of a drain
    dut_fires = 0;
    push_line(32'h0000_A000, mkdata(32'hA0A0_0000));
    for (int n = 0; n < 100 && dut_fires < 7; n++) tick();
    chk("t6_fires_before_rst", dut_fires, 7);
    rst_ni = 1'b0; #1;
    chk("t6_val_now_low", memreq_val, 0);
    chk("t6_empty", empty, 1);
    chk("t6_err_clr", err, 0);
    in_reset = 1;
    model_reset();
    repeat (2) tick();
    rst_ni = 1'b1; in_reset = 0;

    // forwarding lookup on a pending line
    memreq_rdy = 0;
    in_data = mkdata(32'h5000_0000);
    in_data[32*3 +: 32] = 32'hDEAD_BEEF;
    push_line(32'h0000_5000, in_data);
    lookup_addr = 32'h0000_500C; #1;
    chk("t7_fwd_hit", lookup_hit, 1);
`ifdef CACHE_EVICT_BUFFER_FWD_EN
    chk("t7_fwd_data", lookup_data, 32'hDEAD_BEEF);
`else
    chk("t7_fwd_data", lookup_data, 32'h0);
`endif
    memreq_rdy = 1;
    wait_empty(200, "t7_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
